sar_search: RTL and testbench

- Successive-approximation search engine that recovers an unknown DATA_WIDTH-bit target by driving trial values into an external `comparator` instance and consuming its equal/greater/lower flags.
- It is the consumer end of the comparator interface: the comparator judges, this block decides and iterates.
- It sits beside a `comparator` whose `data_0_i` is the target and whose `data_1_i` is `trial_o`. It is used for threshold calibration, ADC SAR control and lookup bracketing.

---
 rtl/sar_search.sv | 135 +++++++++++++
 tb/tb_sar_search.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search engine driving an external comparator; decides one bit per clock, MSB first.
// Optional early termination on an equality flag is enabled by defining SAR_SEARCH_EARLY_EXIT_EN.
module sar_search #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  equal_i,
  input  logic                  greater_i,
  input  logic                  lower_i,
  output logic [DATA_WIDTH-1:0] trial_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  exact_o
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [DATA_WIDTH-1:0] MSB_ONE = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
`ifdef SAR_SEARCH_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRIAL  = 2'd1,
    S_VERIFY = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   trial_q, trial_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    exact_q, exact_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    exact_out_q, exact_out_d;
  logic [DATA_WIDTH-1:0]   bit_mask_s;
  logic [DATA_WIDTH-1:0]   decided_s;

  // Next-state logic: equal beats greater beats lower; no flag at all counts as lower.
  always_comb begin
    state_d     = state_q;
    trial_d     = trial_q;
    idx_d       = idx_q;
    exact_d     = exact_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    exact_out_d = exact_out_q;
    bit_mask_s  = DATA_WIDTH'(1) << idx_q;
    if (equal_i || greater_i) begin
      decided_s = trial_q | bit_mask_s;
    end else begin
      decided_s = trial_q & ~bit_mask_s;
    end
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_TRIAL;
          trial_d = MSB_ONE;
          idx_d   = IDX_TOP;
          exact_d = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIAL: begin
        exact_d = exact_q | equal_i;
        if (EARLY_EXIT && equal_i) begin
          state_d     = S_IDLE;
          result_d    = trial_q;
          exact_out_d = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
        end else if (idx_q != IDX_ZERO) begin
          trial_d = decided_s | (bit_mask_s >> 1);
          idx_d   = idx_q - IDX_ONE;
        end else begin
          trial_d = decided_s;
          state_d = S_VERIFY;
        end
      end
      S_VERIFY: begin
        // The final value gets one more compare so an exact match found only here is still reported.
        state_d     = S_IDLE;
        result_d    = trial_q;
        exact_out_d = exact_q | equal_i;
        done_d      = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      trial_q     <= '0;
      idx_q       <= IDX_ZERO;
      exact_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      exact_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trial_q     <= trial_d;
      idx_q       <= idx_d;
      exact_q     <= exact_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      exact_out_q <= exact_out_d;
    end
  end

  assign trial_o  = trial_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign exact_o  = exact_out_q;

endmodule

// File: tb/tb_sar_search.sv
// Randomized self-checking bench for sar_search with a behavioural comparator and binary-search reference.
module tb_sar_search;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic         equal_i;
  logic         greater_i;
  logic         lower_i;
  logic [W-1:0] trial_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         exact_o;

  logic [W-1:0] target;
  int           fmode;   // 0 honest comparator, 1 no flags, 2 greater and lower both set
  int           checks = 0;
  int           errors = 0;

  sar_search #(.DATA_WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start_i),
    .equal_i  (equal_i),
    .greater_i(greater_i),
    .lower_i  (lower_i),
    .trial_o  (trial_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .exact_o  (exact_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    equal_i   = 1'b0;
    greater_i = 1'b0;
    lower_i   = 1'b0;
    case (fmode)
      0: begin
        equal_i   = (target == trial_o);
        greater_i = (target > trial_o);
        lower_i   = (target < trial_o);
      end
      2: begin
        greater_i = 1'b1;
        lower_i   = 1'b1;
      end
      default: ;
    endcase
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Trial presented before decision c: top c bits of the settled answer, then a single probe bit.
  function automatic int model_trial(input int eff, input int c);
    int keep;
    keep = eff & ~((1 << (W - c)) - 1);
    return keep | (1 << (W - 1 - c));
  endfunction

  function automatic int trailing_zeros(input int v);
    int n;
    n = 0;
    for (int b = 0; b < W; b++) begin
      if (((v >> b) & 1) != 0) return n;
      n++;
    end
    return n;
  endfunction

  task automatic run_search(input int tgt, input int mode, input bit hold_start);
    int eff;
    int exp_lat;
    int exp_exact;
    int lat;
    target = W'(tgt);
    fmode  = mode;
    eff       = (mode == 0) ? tgt : ((mode == 1) ? 0 : (1 << W) - 1);
    exp_exact = (mode == 0) ? 1 : 0;
    exp_lat   = W + 1;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
    if (mode == 0 && tgt != 0) exp_lat = W - trailing_zeros(tgt);
`endif
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    if (!hold_start) start_i = 1'b0;
    check_value("busy_after_start", 32'(busy_o), 32'd1);
    check_value("trial_first", 32'(trial_o), 32'(model_trial(eff, 0)));
    lat = 0;
    for (int c = 1; c <= 3 * W; c++) begin
      @(negedge clk);
      if (done_o) begin
        lat = c;
        break;
      end
      if (c < W) check_value("trial_step", 32'(trial_o), 32'(model_trial(eff, c)));
      else       check_value("trial_final", 32'(trial_o), 32'(eff));
    end
    check_value("latency", 32'(lat), 32'(exp_lat));
    check_value("result", 32'(result_o), 32'(eff));
    check_value("exact", 32'(exact_o), 32'(exp_exact));
    check_value("busy_at_done", 32'(busy_o), 32'd0);
    if (!hold_start) begin
      @(negedge clk);
      check_value("done_one_cycle", 32'(done_o), 32'd0);
      check_value("result_held", 32'(result_o), 32'(eff));
    end
  endtask

  initial begin
    int lat;
    rst_n   = 1'b0;
    start_i = 1'b0;
    target  = '0;
    fmode   = 0;
    repeat (2) @(negedge clk);
    check_value("rst_trial", 32'(trial_o), 32'd0);
    check_value("rst_busy", 32'(busy_o), 32'd0);
    check_value("rst_done", 32'(done_o), 32'd0);
    check_value("rst_result", 32'(result_o), 32'd0);
    check_value("rst_exact", 32'(exact_o), 32'd0);
    rst_n = 1'b1;

    run_search(32'hA5, 0, 1'b0);
    run_search(32'h80, 0, 1'b0);
    run_search(32'h00, 0, 1'b0);
    run_search(32'hFF, 0, 1'b0);
    run_search(32'h01, 0, 1'b0);
    run_search(32'h5A, 1, 1'b0);
    run_search(32'h5A, 2, 1'b0);

    // start held high: exactly one done, then immediate restart from the MSB probe
    run_search(32'h5A, 0, 1'b1);
    @(negedge clk);
    check_value("restart_trial", 32'(trial_o), 32'h80);
    check_value("restart_busy", 32'(busy_o), 32'd1);
    check_value("restart_done_low", 32'(done_o), 32'd0);
    start_i = 1'b0;
    lat = 0;
    for (int c = 1; c <= 3 * W; c++) begin
      @(negedge clk);
      if (done_o) begin
        lat = c;
        break;
      end
    end
    check_value("restart_finished", 32'(lat != 0), 32'd1);
    check_value("restart_result", 32'(result_o), 32'h5A);

    // asynchronous reset while trial 4 is on the bus
    fmode  = 0;
    target = 8'h96;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_value("mid_rst_trial", 32'(trial_o), 32'd0);
    check_value("mid_rst_busy", 32'(busy_o), 32'd0);
    check_value("mid_rst_done", 32'(done_o), 32'd0);
    check_value("mid_rst_result", 32'(result_o), 32'd0);
    check_value("mid_rst_exact", 32'(exact_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_search(32'h3C, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_search(int'($urandom_range(0, (1 << W) - 1)), ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
